// File: rtl/bfp16_div_if.sv
// Handshake/data bundle for bfp16_div.
//   start : request, sampled only while the divider is idle
//   A, B  : dividend / divisor, captured on an accepted start
//   busy  : operation in flight
//   done  : one-cycle pulse, O valid from this cycle
//   O     : registered quotient, held until the next done
interface bfp16_div_if #(
  parameter int DATA_TYPE = 16
);
  logic                 start;
  logic [DATA_TYPE-1:0] A;
  logic [DATA_TYPE-1:0] B;
  logic                 busy;
  logic                 done;
  logic [DATA_TYPE-1:0] O;

  modport master (output start, A, B, input  busy, done, O);
  modport slave  (input  start, A, B, output busy, done, O);
endinterface

// File: rtl/bfp16_div.sv
// Multi-cycle bfloat16 divider, O = A / B.
// Radix-2 restoring mantissa divider, one quotient bit per cycle; fixed
// 10-cycle latency from accepted start to done, specials included.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bfp16_div_if slave (start/A/B in, busy/done/O out)
module bfp16_div #(
  parameter int DATA_TYPE = 16
) (
  input logic        clk,
  input logic        rst,
  bfp16_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [DATA_TYPE-1:0] a_q;
  logic [DATA_TYPE-1:0] b_q;
  logic [8:0]           r;
  logic [8:0]           q;
  logic                 busy_q;
  logic                 done_q;
  logic [DATA_TYPE-1:0] o_q;

  logic [7:0]        ea, eb;
  logic [7:0]        mb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              s;
  logic              r_ge;
  logic [8:0]        r_sub;
  logic [8:0]        r_next;
  logic signed [9:0] e;
  logic [6:0]        mant;
  logic [15:0]       res;

  always_comb begin
    ea     = a_q[14:7];
    eb     = b_q[14:7];
    mb     = {1'b1, b_q[6:0]};
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (a_q[6:0] == 7'h0);
    b_inf  = (eb == 8'hFF) && (b_q[6:0] == 7'h0);
    a_nan  = (ea == 8'hFF) && (a_q[6:0] != 7'h0);
    b_nan  = (eb == 8'hFF) && (b_q[6:0] != 7'h0);
    s      = a_q[15] ^ b_q[15];
  end

  // One restoring step; remainder stays below mb after subtraction, so the
  // left shift never loses a set bit.
  always_comb begin
    r_ge   = (r >= {1'b0, mb});
    r_sub  = r_ge ? (r - {1'b0, mb}) : r;
    r_next = r_sub << 1;
  end

  // Quotient lies in (0.5, 2): q[8] is the 2^0 bit, otherwise q[7] leads.
  always_comb begin
    e    = $signed({2'b00, ea}) - $signed({2'b00, eb})
           + (q[8] ? 10'sd127 : 10'sd126);
    mant = q[8] ? q[7:1] : q[6:0];
    res  = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      res = 16'h7FC0;
    else if (a_inf || b_zero)
      res = {s, 8'hFF, 7'h0};
    else if (a_zero || b_inf)
      res = {s, 15'h0};
    else if (e >= 10'sd255)
      res = {s, 8'hFF, 7'h0};
    else if (e <= 10'sd0)
      res = {s, 15'h0};
    else
      res = {s, e[7:0], mant};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      r      <= '0;
      q      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      o_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            r      <= {2'b01, bus.A[6:0]};
            q      <= '0;
            cnt    <= 4'd8;
            busy_q <= 1'b1;
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          r <= r_next;
          q <= {q[7:0], r_ge};
          if (cnt == 4'd0)
            state <= FINISH;
          else
            cnt <= cnt - 4'd1;
        end
        FINISH: begin
          o_q    <= res;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.O    = o_q;

endmodule

// File: tb/tb_bfp16_div.sv
module tb_bfp16_div;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bfp16_div_if #(.DATA_TYPE(16)) bus ();

  bfp16_div #(.DATA_TYPE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start an operation, scramble A/B after acceptance, then check the
  // 10-cycle busy/done timeline and the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    step();
    bus.start = 1'b0;
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0001;
    chk({tag, "_busy0"}, {15'h0, bus.busy}, 16'h1);
    for (int n = 1; n <= 10; n++) begin
      step();
      chk($sformatf("%s_done%0d", tag, n), {15'h0, bus.done}, {15'h0, n == 10});
      chk($sformatf("%s_busy%0d", tag, n), {15'h0, bus.busy}, {15'h0, n != 10});
      if (n == 10) chk({tag, "_O"}, bus.O, exp);
    end
  endtask

  initial begin
    logic [15:0] hs_a, hs_b, hs_o;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    step();
    step();
    chk("rst_busy", {15'h0, bus.busy}, 16'h0);
    chk("rst_done", {15'h0, bus.done}, 16'h0);
    chk("rst_O", bus.O, 16'h0000);
    rst = 1'b0;
    step();

    run_op("two_by_one", 16'h4000, 16'h3F80, 16'h4000);
    run_op("one_third",  16'h3F80, 16'h4040, 16'h3EAA);
    run_op("neg6_by_2",  16'hC0C0, 16'h4000, 16'hC040);
    run_op("x_by_zero",  16'h3F80, 16'h0000, 16'h7F80);
    run_op("zero_zero",  16'h0000, 16'h0000, 16'h7FC0);
    run_op("nan_in",     16'h7FC0, 16'h3F80, 16'h7FC0);
    run_op("denorm",     16'h003F, 16'h3F02, 16'h0000);
    run_op("inf_inf",    16'hFF80, 16'h7F80, 16'h7FC0);
    run_op("inf_by_x",   16'hFF80, 16'h3F80, 16'hFF80);
    run_op("x_by_inf",   16'h3F80, 16'hFF80, 16'h8000);
    run_op("overflow",   16'h7F00, 16'h0080, 16'h7F80);
    run_op("underflow",  16'h0080, 16'h7F00, 16'h0000);
    run_op("uflow_neg",  16'h8080, 16'h4000, 16'h8000);

    // Reset in the middle of DIVIDE drops the operation.
    bus.start = 1'b1;
    bus.A     = 16'h3F80;
    bus.B     = 16'h4040;
    step();
    bus.start = 1'b0;
    for (int n = 1; n <= 4; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {15'h0, bus.busy}, 16'h0);
    chk("midrst_done", {15'h0, bus.done}, 16'h0);
    chk("midrst_O", bus.O, 16'h0000);
    for (int n = 1; n <= 15; n++) begin
      step();
      chk($sformatf("midrst_nodone%0d", n), {15'h0, bus.done}, 16'h0);
    end

    // rst and start together: start must not be accepted.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 16'h4000;
    bus.B     = 16'h3F80;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", {15'h0, bus.busy}, 16'h0);
    step();
    chk("rst_start_busy2", {15'h0, bus.busy}, 16'h0);

    run_op("after_rst", 16'h4000, 16'h3F80, 16'h4000);

    // start held high with new operands every cycle: accepted at i=0,11,22.
    for (int i = 0; i <= 32; i++) begin
      case (i)
        0:       begin hs_a = 16'h4000; hs_b = 16'h3F80; end
        11:      begin hs_a = 16'h3F80; hs_b = 16'h4040; end
        22:      begin hs_a = 16'hC0C0; hs_b = 16'h4000; end
        default: begin hs_a = 16'h4100 + 16'(i); hs_b = 16'h3F80; end
      endcase
      bus.start = 1'b1;
      bus.A     = hs_a;
      bus.B     = hs_b;
      step();
      chk($sformatf("hs_done%0d", i), {15'h0, bus.done}, {15'h0, (i % 11) == 10});
      chk($sformatf("hs_busy%0d", i), {15'h0, bus.busy}, {15'h0, (i % 11) != 10});
      if ((i % 11) == 10) begin
        case (i / 11)
          0:       hs_o = 16'h4000;
          1:       hs_o = 16'h3EAA;
          default: hs_o = 16'hC040;
        endcase
        chk($sformatf("hs_O%0d", i / 11), bus.O, hs_o);
      end
    end
    bus.start = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
